// File: rtl/mixcol_ark_stage.sv
// Column-serial MixColumns + AddRoundKey stage over the redundant (8+d)-bit ring.
// Optional MIXCOL_ARK_REFRESH_EN adds rand_i, XORed into every written column.

module mix_column_single #(
  parameter int d = 4,
  parameter logic [0:7+d][0:7+d] L_two = '0
) (
  input  logic [3:0][0:7+d] col_i,
  output logic [3:0][0:7+d] col_o
);
  localparam int W = 8 + d;

  // Multiply-by-2 is a linear map in the ring: output bit i is row i of L_two dotted with x.
  function automatic logic [0:W-1] mul2(input logic [0:W-1] x);
    logic [0:W-1] y;
    for (int i = 0; i < W; i++) y[i] = ^(L_two[i] & x);
    return y;
  endfunction

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign col_o[r] = mul2(col_i[r] ^ col_i[(r+1)%4]) ^ col_i[(r+1)%4]
                    ^ col_i[(r+2)%4] ^ col_i[(r+3)%4];
  end
endmodule

module mixcol_ark_stage #(
  parameter int d = 4,
  parameter logic [0:7+d][0:7+d] L_two = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0][0:7+d]    state_i,
  input  logic [15:0][0:7+d]    key_i,
  input  logic                  last_round_i,
`ifdef MIXCOL_ARK_REFRESH_EN
  input  logic [3:0][0:7+d]     rand_i,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0][0:7+d]    state_o
);
  localparam int W = 8 + d;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e                fsm_q, fsm_d;
  logic [1:0]          col_cnt_q, col_cnt_d;
  logic [15:0][0:W-1]  st_q, st_d, key_q, key_d, out_q, out_d;
  logic                last_q, last_d, out_valid_q, out_valid_d;
  logic [3:0][0:W-1]   col, mix_full, mixed, wr_col;
  logic [3:0]          base;
  logic                accept;

  assign in_ready  = (fsm_q == IDLE) || (fsm_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign state_o   = out_q;

  assign base = {col_cnt_q, 2'b00};
  assign col  = st_q[base +: 4];

  mix_column_single #(.d(d), .L_two(L_two)) u_mix (
    .col_i (col),
    .col_o (mix_full)
  );

  assign mixed = last_q ? col : mix_full;
`ifdef MIXCOL_ARK_REFRESH_EN
  assign wr_col = mixed ^ key_q[base +: 4] ^ rand_i;
`else
  assign wr_col = mixed ^ key_q[base +: 4];
`endif

  always_comb begin
    fsm_d       = fsm_q;
    col_cnt_d   = col_cnt_q;
    st_d        = st_q;
    key_d       = key_q;
    last_d      = last_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      RUN: begin
        out_d[base +: 4] = wr_col;
        col_cnt_d        = col_cnt_q + 2'd1;
        if (col_cnt_q == 2'd3) begin
          fsm_d       = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        fsm_d       = IDLE;
      end
      default: ;
    endcase
    // Accept only happens from IDLE or a DONE hand-off, so it overrides the above.
    if (accept) begin
      st_d        = state_i;
      key_d       = key_i;
      last_d      = last_round_i;
      col_cnt_d   = 2'd0;
      out_valid_d = 1'b0;
      fsm_d       = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      col_cnt_q   <= 2'd0;
      st_q        <= '0;
      key_q       <= '0;
      last_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      col_cnt_q   <= col_cnt_d;
      st_q        <= st_d;
      key_q       <= key_d;
      last_q      <= last_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
